ins_fetch_q: RTL and testbench

Parametrised instruction-fetch unit that replaces the single-entry fetch stage.
- Issues pipelined, in-order requests to external instruction memory and buffers returned words with their PCs in a DEPTH-entry prefetch queue.
- Presents the queue head to decode under a real stall input.
- On a branch redirect, flushes the queue and discards responses still in flight.

---
 rtl/ins_fetch_q.sv | 168 ++++++++++++++++
 tb/tb_ins_fetch_q.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ins_fetch_q.sv
`default_nettype none
// ============================================================================
//  Module   : ins_fetch_q
//  Purpose  : Instruction-fetch unit with a DEPTH-entry prefetch queue.
//             Issues pipelined in-order requests to instruction memory.
//             Queues returned words with their PCs. Presents the head
//             entry to decode under stall. On a redirect it flushes the
//             queue and discards responses that are still in flight.
//  Options  : INS_FETCH_Q_BYPASS_EN - when defined, a response that arrives
//             while the queue is empty is shown on the head outputs in the
//             same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module ins_fetch_q #(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUTS = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_en,
    input  logic [31:0] br_addr,
    input  logic        exIns_valid,
    input  logic [31:0] exIns_in,
    output logic        exIns_ren,
    output logic [31:0] exIns_addr,
    output logic        ins_valid,
    output logic [31:0] pc,
    output logic [31:0] ins_out
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_OUT_W = $clog2(MAX_OUTS + 1);

    // Queue storage and bookkeeping
    logic [31:0]        r_q_pc  [DEPTH];
    logic [31:0]        r_q_ins [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Fetch-side state
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [31:0]        r_last_pc;
    logic [c_OUT_W-1:0] r_inflight;
    logic [c_OUT_W-1:0] r_drop_cnt;

    logic [31:0]        w_resv;
    logic [31:0]        w_outs;
    logic               w_ren;
    logic               w_drop;
    logic               w_accept;
    logic               w_empty;
    logic               w_byp_take;
    logic               w_push;
    logic               w_pop;
    logic               w_drop_dec;
    logic [c_OUT_W-1:0] w_drop_br;

    // Queue slots are reserved at request time, so the queue cannot overflow.
    // The outstanding limit also counts requests that are being discarded.
    assign w_resv     = 32'(r_count) + 32'(r_inflight);
    assign w_outs     = 32'(r_inflight) + 32'(r_drop_cnt);
    assign w_ren      = !rst && !br_en && (w_resv < 32'(DEPTH)) && (w_outs < 32'(MAX_OUTS));
    assign exIns_ren  = w_ren;
    assign exIns_addr = r_fetch_pc;

    assign w_empty    = (r_count == '0);
    assign w_drop     = exIns_valid && (r_drop_cnt != '0);
    assign w_accept   = exIns_valid && (r_drop_cnt == '0) && !br_en && !rst;

`ifdef INS_FETCH_Q_BYPASS_EN
    logic w_byp_show;
    // An accepted response into an empty queue is shown directly. It is
    // consumed without being queued unless decode stalls.
    assign w_byp_show = w_accept && w_empty;
    assign w_byp_take = w_byp_show && !stall;
`else
    assign w_byp_take = 1'b0;
`endif

    assign w_push     = w_accept && !w_byp_take;
    assign w_pop      = !w_empty && !stall && !rst;

    // On a redirect every outstanding request becomes a discard, except a
    // response that arrives in this same cycle. The total never exceeds
    // MAX_OUTS, so the c_OUT_W-bit arithmetic is exact.
    assign w_drop_dec = exIns_valid && ((r_drop_cnt != '0) || (r_inflight != '0));
    assign w_drop_br  = r_drop_cnt + r_inflight - c_OUT_W'(w_drop_dec);

    // Head presentation. PC holds the last head value while the queue is empty.
    always_comb begin
        ins_valid = 1'b0;
        pc        = r_last_pc;
        ins_out   = NOP_INST;
        if (rst) begin
            pc = RESET_PC;
        end else if (!w_empty) begin
            ins_valid = 1'b1;
            pc        = r_q_pc[r_rd_ptr];
            ins_out   = r_q_ins[r_rd_ptr];
        end
`ifdef INS_FETCH_Q_BYPASS_EN
        else if (w_byp_show) begin
            ins_valid = 1'b1;
            pc        = r_resp_pc;
            ins_out   = exIns_in;
        end
`endif
    end

    // Queue payload write; the contents need no reset because count gates them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]  <= r_resp_pc;
            r_q_ins[r_wr_ptr] <= exIns_in;
        end
    end

    // Control state: pointers, count, PCs and outstanding-request counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_last_pc  <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_last_pc <= pc;
            if (br_en) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_fetch_pc <= br_addr;
                r_resp_pc  <= br_addr;
                r_inflight <= '0;
                r_drop_cnt <= w_drop_br;
            end else begin
                if (w_ren) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_accept) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - c_OUT_W'(1);
                end
                r_count    <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
                r_inflight <= r_inflight + c_OUT_W'(w_ren) - c_OUT_W'(w_accept);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ins_fetch_q.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ins_fetch_q
//  Purpose  : Self-checking bench for ins_fetch_q (default configuration).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ins_fetch_q;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        br_en;
    logic [31:0] br_addr;
    logic        exIns_valid;
    logic [31:0] exIns_in;
    logic        exIns_ren;
    logic [31:0] exIns_addr;
    logic        ins_valid;
    logic [31:0] pc;
    logic [31:0] ins_out;

    ins_fetch_q #(
        .DEPTH    (4),
        .MAX_OUTS (2),
        .RESET_PC (c_RESET_PC),
        .NOP_INST (c_NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .br_en       (br_en),
        .br_addr     (br_addr),
        .exIns_valid (exIns_valid),
        .exIns_in    (exIns_in),
        .exIns_ren   (exIns_ren),
        .exIns_addr  (exIns_addr),
        .ins_valid   (ins_valid),
        .pc          (pc),
        .ins_out     (ins_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;
    int lat;
    int delivered;
    logic [31:0] exp_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t        pend[$];
    logic [31:0] req_log[$];

    logic        s_ren;
    logic [31:0] s_addr;
    logic        s_v;
    logic [31:0] s_pc;
    logic [31:0] s_ins;

    typedef struct {
        bit          st;
        bit          br;
        logic [31:0] ba;
        bit          ren;
        logic [31:0] addr;
        bit          v;
        logic [31:0] pc;
    } vec_t;
    vec_t vt [19];

    // Memory contents: a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: drive inputs and the memory response, sample outputs,
    // log requests, score deliveries, then advance to the next falling edge.
    task automatic cycle(input bit st, input bit br, input logic [31:0] ba);
        stall   = st;
        br_en   = br;
        br_addr = ba;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            exIns_valid = 1'b1;
            exIns_in    = memf(pend[0].addr);
            pend.delete(0);
        end else begin
            exIns_valid = 1'b0;
            exIns_in    = 32'hDEAD_BEEF;
        end
        #1;
        s_ren  = exIns_ren;
        s_addr = exIns_addr;
        s_v    = ins_valid;
        s_pc   = pc;
        s_ins  = ins_out;
        if (exIns_ren) begin
            pend.push_back('{exIns_addr, cyc + lat});
            req_log.push_back(exIns_addr);
        end
        if (br) begin
            exp_pc = ba;
        end else if (ins_valid && !st) begin
            chk("deliver_pc", pc, exp_pc);
            chk("deliver_ins", ins_out, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            chk("rst_ren", 32'(s_ren), 32'd0);
            chk("rst_valid", 32'(s_v), 32'd0);
            chk("rst_pc", s_pc, c_RESET_PC);
            chk("rst_ins", s_ins, c_NOP);
        end
        rst = 1'b0;
        pend.delete();
        req_log.delete();
        cyc       = 0;
        exp_pc    = c_RESET_PC;
        delivered = 0;
    endtask

    task automatic run_until(input string nm, input int target, input int budget);
        int n = 0;
        while (delivered < target && n < budget) begin
            cycle(1'b0, 1'b0, 32'h0);
            n++;
        end
        chk(nm, 32'(delivered), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // cycle 0 is the first cycle with rst low; memory latency 1
        vt = '{
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h00},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h00},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h00},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h04},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h08},
            '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h08},
            '{1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h08},
            '{1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h08},
            '{1'b1, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h08},
            '{1'b0, 1'b0, 32'h0,   1'b0, 32'h18,  1'b1, 32'h08},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h0C},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h10},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 32'h14},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h24,  1'b1, 32'h18},
            '{1'b0, 1'b1, 32'h100, 1'b0, 32'h28,  1'b1, 32'h1C},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h1C},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h1C},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100},
            '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104}
        };

        cyc = 0;
        lat = 1;
        exp_pc = c_RESET_PC;
        delivered = 0;

        // Reset, streaming, stall fill/release and redirect, L=1
        do_reset(2);
        for (int i = 0; i < 19; i++) begin
            cycle(vt[i].st, vt[i].br, vt[i].ba);
            chk("tbl_ren", 32'(s_ren), 32'(vt[i].ren));
            chk("tbl_addr", s_addr, vt[i].addr);
            chk("tbl_valid", 32'(s_v), 32'(vt[i].v));
            chk("tbl_pc", s_pc, vt[i].pc);
            chk("tbl_ins", s_ins, vt[i].v ? memf(vt[i].pc) : c_NOP);
        end

        // Stall from reset release: exactly DEPTH requests, head frozen
        lat = 1;
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            if (s_v) begin
                chk("stall_pc_hold", s_pc, c_RESET_PC);
            end
        end
        chk("stall_req_count", 32'(req_log.size()), 32'd4);
        chk("stall_ren_off", 32'(s_ren), 32'd0);
        chk("stall_valid", 32'(s_v), 32'd1);
        chk("stall_ins", s_ins, memf(c_RESET_PC));
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
        end
        chk("release_pops", 32'(delivered), 32'd4);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
        end
        chk("fetch_resumes", 32'(req_log.size() > 4), 32'd1);

        // Redirect with two requests outstanding, L=3
        lat = 3;
        do_reset(1);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h100);
        chk("br_no_req", 32'(s_ren), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("br_next_valid", 32'(s_v), 32'd0);
        chk("br_drop_hold", 32'(s_ren), 32'd0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("br_first_ren", 32'(s_ren), 32'd1);
        chk("br_first_addr", s_addr, 32'h100);
        run_until("br_progress", 3, 40);

        // Redirect coincident with a response while stalled, L=2
        lat = 2;
        do_reset(1);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h200);
        cycle(1'b1, 1'b0, 32'h0);
        chk("co_valid", 32'(s_v), 32'd0);
        chk("co_ren", 32'(s_ren), 32'd1);
        chk("co_addr", s_addr, 32'h200);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("co_head_valid", 32'(s_v), 32'd1);
        chk("co_head_pc", s_pc, 32'h200);
        chk("co_head_ins", s_ins, memf(32'h200));
        run_until("co_progress", 3, 40);

        // Reset mid-stream with responses still pending, L=3
        lat = 3;
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
        end
        chk("mid_pending", 32'(pend.size() != 0), 32'd1);
        do_reset(2);
        cycle(1'b0, 1'b0, 32'h0);
        chk("mid_valid", 32'(s_v), 32'd0);
        chk("mid_pc", s_pc, c_RESET_PC);
        chk("mid_addr", s_addr, c_RESET_PC);
        run_until("mid_progress", 2, 40);

        // Address wrap at the top of the 32-bit space, L=1
        lat = 1;
        do_reset(1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
        run_until("wrap_progress", 4, 40);
        chk("wrap_req0", req_log[0], 32'hFFFF_FFF8);
        chk("wrap_req1", req_log[1], 32'hFFFF_FFFC);
        chk("wrap_req2", req_log[2], 32'h0000_0000);
        chk("wrap_req3", req_log[3], 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
